// File: rtl/bool_packing_scheduler.sv
// Buffers a mixed CDF/Boolean symbol stream and issues one bundle per cycle: a lone CDF
// symbol or a run of 1-3 consecutive bools, with a wait timeout and end-of-frame flush.
module bool_packing_scheduler #(
  parameter int RANGE_WIDTH  = 16,
  parameter int SYMBOL_WIDTH = 4,
  parameter int DEPTH        = 4,
  parameter int MAX_WAIT     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_bool,
  input  logic [SYMBOL_WIDTH-1:0] in_symbol,
  input  logic [RANGE_WIDTH-1:0]  in_fl,
  input  logic [RANGE_WIDTH-1:0]  in_fh,
  input  logic                    in_flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_bool_1,
  output logic                    out_bool_2,
  output logic                    out_bool_3,
  output logic [SYMBOL_WIDTH-1:0] out_symbol_1,
  output logic [SYMBOL_WIDTH-1:0] out_symbol_2,
  output logic [SYMBOL_WIDTH-1:0] out_symbol_3,
  output logic [RANGE_WIDTH-1:0]  out_fl,
  output logic [RANGE_WIDTH-1:0]  out_fh,
  output logic                    flush_done
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  logic                    buf_bool [DEPTH];
  logic [SYMBOL_WIDTH-1:0] buf_sym  [DEPTH];
  logic [RANGE_WIDTH-1:0]  buf_fl   [DEPTH];
  logic [RANGE_WIDTH-1:0]  buf_fh   [DEPTH];

  logic [PW-1:0]           rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]           count_reg;
  logic [WW-1:0]           wait_cnt_reg;
  logic                    flush_pending_reg;
  logic                    out_valid_reg;
  logic [2:0]              out_flag_reg;
  logic [SYMBOL_WIDTH-1:0] out_sym_reg [3];
  logic [RANGE_WIDTH-1:0]  out_fl_reg, out_fh_reg;

  logic [PW-1:0]           peek_idx [3];
  logic [2:0]              lane_present, lane_bool, lane_flag;
  logic [SYMBOL_WIDTH-1:0] lane_sym [3];
  logic [1:0]              run_len, pop_cnt;
  logic                    head_cdf, bool_ready, formable, load, accept, flush_done_int;

  // Look at the first three buffered entries; lanes beyond the fill level read as absent.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign peek_idx[gi]     = rd_ptr_reg + PW'(gi);
      assign lane_present[gi] = count_reg > CW'(gi);
      assign lane_bool[gi]    = lane_present[gi] & buf_bool[peek_idx[gi]];
      assign lane_flag[gi]    = run_len > 2'(gi);
      assign lane_sym[gi]     = (lane_flag[gi] | (head_cdf & (gi == 0))) ? buf_sym[peek_idx[gi]] : '0;
    end
  endgenerate

  always_comb begin
    run_len = 2'd0;
    if (lane_bool[0]) run_len = lane_bool[1] ? (lane_bool[2] ? 2'd3 : 2'd2) : 2'd1;
  end

  assign head_cdf = lane_present[0] & ~buf_bool[rd_ptr_reg];
  // A short run may go only once it can no longer grow, has waited long enough, or a flush is on.
  assign bool_ready = (run_len == 2'd3) || (count_reg > CW'(run_len)) ||
                      (wait_cnt_reg == WAIT_LAST) || flush_pending_reg;
  assign formable       = head_cdf | ((run_len != 2'd0) & bool_ready);
  assign load           = formable & (~out_valid_reg | out_ready);
  assign pop_cnt        = !load ? 2'd0 : (head_cdf ? 2'd1 : run_len);
  assign in_ready       = ~reset & (count_reg < CW'(DEPTH));
  assign accept         = in_valid & in_ready;
  assign flush_done_int = flush_pending_reg & (count_reg == '0) & ~out_valid_reg;

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_bool[wr_ptr_reg] <= in_bool;
      buf_sym[wr_ptr_reg]  <= in_symbol;
      buf_fl[wr_ptr_reg]   <= in_fl;
      buf_fh[wr_ptr_reg]   <= in_fh;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg        <= '0;
      wr_ptr_reg        <= '0;
      count_reg         <= '0;
      wait_cnt_reg      <= '0;
      flush_pending_reg <= 1'b0;
      out_valid_reg     <= 1'b0;
      out_flag_reg      <= '0;
      out_fl_reg        <= '0;
      out_fh_reg        <= '0;
      for (int i = 0; i < 3; i++) out_sym_reg[i] <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_reg + PW'(pop_cnt);
      wr_ptr_reg <= wr_ptr_reg + PW'(accept);
      count_reg  <= count_reg + CW'(accept) - CW'(pop_cnt);

      if (!lane_bool[0] || load)       wait_cnt_reg <= '0;
      else if (wait_cnt_reg != WAIT_LAST) wait_cnt_reg <= wait_cnt_reg + 1'b1;

      if (flush_done_int) flush_pending_reg <= 1'b0;
      else if (in_flush)  flush_pending_reg <= 1'b1;

      if (load) begin
        out_valid_reg <= 1'b1;
        out_flag_reg  <= lane_flag;
        out_fl_reg    <= head_cdf ? buf_fl[rd_ptr_reg] : '0;
        out_fh_reg    <= head_cdf ? buf_fh[rd_ptr_reg] : '0;
        for (int i = 0; i < 3; i++) out_sym_reg[i] <= lane_sym[i];
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
        out_flag_reg  <= '0;
        out_fl_reg    <= '0;
        out_fh_reg    <= '0;
        for (int i = 0; i < 3; i++) out_sym_reg[i] <= '0;
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_bool_1   = out_flag_reg[0];
  assign out_bool_2   = out_flag_reg[1];
  assign out_bool_3   = out_flag_reg[2];
  assign out_symbol_1 = out_sym_reg[0];
  assign out_symbol_2 = out_sym_reg[1];
  assign out_symbol_3 = out_sym_reg[2];
  assign out_fl       = out_fl_reg;
  assign out_fh       = out_fh_reg;
  assign flush_done   = flush_done_int;
endmodule

// File: tb/tb_bool_packing_scheduler.sv
// Randomized and directed bench for bool_packing_scheduler against a queue-based reference model.
module tb_bool_packing_scheduler;
  localparam int RW = 16;
  localparam int SW = 4;
  localparam int DEPTH = 4;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset, in_valid, in_bool, in_flush, out_ready;
  logic [SW-1:0] in_symbol;
  logic [RW-1:0] in_fl, in_fh;
  logic in_ready, out_valid, out_bool_1, out_bool_2, out_bool_3, flush_done;
  logic [SW-1:0] out_symbol_1, out_symbol_2, out_symbol_3;
  logic [RW-1:0] out_fl, out_fh;

  bool_packing_scheduler #(.RANGE_WIDTH(RW), .SYMBOL_WIDTH(SW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_bool(in_bool),
    .in_symbol(in_symbol), .in_fl(in_fl), .in_fh(in_fh), .in_flush(in_flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_bool_1(out_bool_1), .out_bool_2(out_bool_2),
    .out_bool_3(out_bool_3), .out_symbol_1(out_symbol_1), .out_symbol_2(out_symbol_2),
    .out_symbol_3(out_symbol_3), .out_fl(out_fl), .out_fh(out_fh), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic [SW-1:0] s;
    logic [RW-1:0] fl, fh;
  } ent_t;
  typedef struct {
    logic [2:0] f;
    logic [SW-1:0] s1, s2, s3;
    logic [RW-1:0] fl, fh;
  } bundle_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Reference model state
  ent_t mq[$];
  int m_wait = 0;
  bit m_pend = 0;
  bit m_ov = 0;
  bundle_t m_out;
  int m_k, m_n;
  bit m_form, m_load, m_acc, m_fd;

  bundle_t log_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: the buffer is a queue; bundle rules are applied to its contents at cycle start.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_wait = 0;
      m_pend = 0;
      m_ov = 0;
    end else begin
      m_form = 0;
      m_n = 0;
      if (mq.size() > 0) begin
        if (!mq[0].b) begin
          m_form = 1;
          m_n = 1;
        end else begin
          m_k = 0;
          while (m_k < 3 && m_k < mq.size() && mq[m_k].b) m_k++;
          m_form = (m_k == 3) || (mq.size() > m_k) || (m_wait == MAX_WAIT - 1) || m_pend;
          m_n = m_k;
        end
      end
      m_fd = m_pend && mq.size() == 0 && !m_ov;
      m_acc = in_valid && mq.size() < DEPTH;
      m_load = m_form && (!m_ov || out_ready);
      if (m_load) begin
        m_ov = 1;
        m_out.f = '0; m_out.s1 = '0; m_out.s2 = '0; m_out.s3 = '0; m_out.fl = '0; m_out.fh = '0;
        if (!mq[0].b) begin
          m_out.s1 = mq[0].s; m_out.fl = mq[0].fl; m_out.fh = mq[0].fh;
        end else begin
          m_out.f[0] = 1'b1; m_out.s1 = mq[0].s;
          if (m_n > 1) begin m_out.f[1] = 1'b1; m_out.s2 = mq[1].s; end
          if (m_n > 2) begin m_out.f[2] = 1'b1; m_out.s3 = mq[2].s; end
        end
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (mq.size() == 0 || !mq[0].b || m_load) m_wait = 0;
      else if (m_wait < MAX_WAIT - 1) m_wait++;
      if (m_fd) m_pend = 0;
      else if (in_flush) m_pend = 1;
      if (m_load) repeat (m_n) void'(mq.pop_front());
      if (m_acc) mq.push_back('{b: in_bool, s: in_symbol, fl: in_fl, fh: in_fh});
    end
  end

  // Compare process, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!reset && mq.size() < DEPTH)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      chk("flush_done", {31'd0, flush_done}, {31'd0, (m_pend && mq.size() == 0 && !m_ov)});
      if (m_ov && out_valid) begin
        chk("out_flags", {29'd0, out_bool_3, out_bool_2, out_bool_1}, {29'd0, m_out.f});
        chk("out_symbol_1", {28'd0, out_symbol_1}, {28'd0, m_out.s1});
        chk("out_symbol_2", {28'd0, out_symbol_2}, {28'd0, m_out.s2});
        chk("out_symbol_3", {28'd0, out_symbol_3}, {28'd0, m_out.s3});
        chk("out_fl", {16'd0, out_fl}, {16'd0, m_out.fl});
        chk("out_fh", {16'd0, out_fh}, {16'd0, m_out.fh});
      end
      if (out_valid && out_ready)
        log_q.push_back('{f: {out_bool_3, out_bool_2, out_bool_1}, s1: out_symbol_1,
                          s2: out_symbol_2, s3: out_symbol_3, fl: out_fl, fh: out_fh});
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    log_q.delete();
  endtask

  task automatic send(input logic b, input logic [SW-1:0] s, input logic [RW-1:0] fl, input logic [RW-1:0] fh);
    in_valid = 1'b1; in_bool = b; in_symbol = s; in_fl = fl; in_fh = fh;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_random(input int cycles, input int pv, input int pb, input int pr, input int pf);
    for (int i = 0; i < cycles; i++) begin
      in_valid  = ($urandom_range(99) < pv);
      in_bool   = ($urandom_range(99) < pb);
      in_symbol = SW'($urandom);
      in_fl     = RW'($urandom);
      in_fh     = RW'($urandom);
      out_ready = ($urandom_range(99) < pr);
      in_flush  = ($urandom_range(999) < pf);
      reset     = ($urandom_range(999) < 3);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_flush = 1'b0; reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tv, tf, tfd, nfd;
    bit found;
    reset = 1'b1; in_valid = 0; in_bool = 0; in_flush = 0; out_ready = 0;
    in_symbol = '0; in_fl = '0; in_fh = '0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Three bools back-to-back form one full bundle.
    out_ready = 1'b1;
    do_reset();
    send(1'b1, 4'd1, 16'h0, 16'h0);
    send(1'b1, 4'd0, 16'h0, 16'h0);
    send(1'b1, 4'd1, 16'h0, 16'h0);
    repeat (8) @(posedge clk); #1;
    chk("t1_bundles", log_q.size(), 32'd1);
    if (log_q.size() > 0) begin
      chk("t1_flags", {29'd0, log_q[0].f}, 32'd7);
      chk("t1_syms", {20'd0, log_q[0].s1, log_q[0].s2, log_q[0].s3}, 32'h101);
    end

    // Bool then CDF: the CDF behind it releases the lone bool.
    do_reset();
    send(1'b1, 4'd1, 16'h0, 16'h0);
    send(1'b0, 4'd5, 16'h4000, 16'h2000);
    repeat (8) @(posedge clk); #1;
    chk("t2_bundles", log_q.size(), 32'd2);
    if (log_q.size() > 1) begin
      chk("t2a_flags", {29'd0, log_q[0].f}, 32'd1);
      chk("t2a_sym1", {28'd0, log_q[0].s1}, 32'd1);
      chk("t2b_flags", {29'd0, log_q[1].f}, 32'd0);
      chk("t2b_sym1", {28'd0, log_q[1].s1}, 32'd5);
      chk("t2b_fl", {16'd0, log_q[1].fl}, 32'h4000);
      chk("t2b_fh", {16'd0, log_q[1].fh}, 32'h2000);
    end

    // Lone bool times out after MAX_WAIT cycles at the head.
    do_reset();
    send(1'b1, 4'd9, 16'h0, 16'h0);
    t0 = cyc; tv = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin found = 1; tv = cyc; end
    end
    chk("t3_issued", {31'd0, found}, 32'd1);
    if (found) chk("t3_latency", tv - t0, MAX_WAIT);
    repeat (3) @(posedge clk); #1;

    // Two bools then flush: issued without waiting, flush_done after consumption.
    do_reset();
    send(1'b1, 4'd3, 16'h0, 16'h0);
    send(1'b1, 4'd2, 16'h0, 16'h0);
    in_flush = 1'b1;
    @(posedge clk); #1;
    in_flush = 1'b0;
    tf = cyc; tv = -100; tfd = -100; nfd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid && tv < 0) tv = cyc;
      if (flush_done) begin nfd++; if (tfd < 0) tfd = cyc; end
    end
    chk("t5_issue_delay", tv - tf, 32'd1);
    chk("t5_flush_done_count", nfd, 32'd1);
    chk("t5_flush_done_delay", tfd - tv, 32'd1);
    if (log_q.size() > 0) begin
      chk("t5_flags", {29'd0, log_q[0].f}, 32'd3);
      chk("t5_syms", {20'd0, log_q[0].s1, log_q[0].s2, log_q[0].s3}, 32'h320);
    end
    @(posedge clk); #1;

    // Reset while entries are buffered and a bundle is held.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(1'b1, 4'(i), 16'h0, 16'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    log_q.delete();
    @(negedge clk);
    chk("t6_out_valid_after_reset", {31'd0, out_valid}, 32'd0);
    repeat (10) @(posedge clk); #1;
    chk("t6_no_stale_bundle", log_q.size(), 32'd0);

    // Randomized traffic of several flavours.
    run_random(800, 60, 70, 80, 10);
    run_random(800, 90, 95, 30, 5);
    run_random(800, 30, 50, 90, 30);
    run_random(800, 70, 85, 60, 15);
    out_ready = 1'b1;
    repeat (20) @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
